// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths, parameter defaults and FSM encoding for the RAM arbiter.
package ram_arbiter_pkg;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int GAP_DEF = 2;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ACK, GAP} state_t;
endpackage

// File: rtl/done_sync.sv
// done_sync: two-flop synchronizer for mem_done with a third flop for rising-edge detect.
module done_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else s_q <= s_d;
  assign level = s_q[1];
  assign rise = s_q[1] & ~s_q[2];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter of two requesters onto one RAM controller,
// with done synchronization, timeout abort and an inter-access gap.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic          req0_err,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic          req1_err,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_en,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES) + 1);
  state_t st_q, st_d;
  logic gnt_q, gnt_d, pri_q, pri_d, we_q, we_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_lvl, done_rise, act;
  done_sync u_sync (.clk(clk), .rst(rst), .d(mem_done), .level(done_lvl), .rise(done_rise));
  always_comb begin
    st_d = st_q;
    gnt_d = gnt_q;
    pri_d = pri_q;
    we_d = we_q;
    err_d = err_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    cnt_d = cnt_q;
    case (st_q)
      IDLE: if (req0_valid | req1_valid) begin
        // pri_q names the requester that wins a tie; it starts at 0
        gnt_d = (req0_valid & req1_valid) ? pri_q : req1_valid;
        pri_d = ~gnt_d;
        we_d = gnt_d ? req1_we : req0_we;
        addr_d = gnt_d ? req1_addr : req0_addr;
        wdata_d = gnt_d ? req1_wdata : req0_wdata;
        st_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        st_d = WAIT_DONE;
      end
      WAIT_DONE: if (done_rise) begin
        err_d = 1'b0;
        rd0_d = (!we_q && !gnt_q) ? mem_rdata : rd0_q;
        rd1_d = (!we_q && gnt_q) ? mem_rdata : rd1_q;
        st_d = ACK;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        err_d = 1'b1;
        st_d = ACK;
      end else cnt_d = cnt_q + 1'b1;
      ACK: begin
        cnt_d = '0;
        st_d = GAP;
      end
      GAP: if (cnt_q >= CW'(GAP_CYCLES - 1) && !done_lvl) st_d = IDLE;
      else if (cnt_q < CW'(GAP_CYCLES - 1)) cnt_d = cnt_q + 1'b1;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      gnt_q <= 1'b0;
      pri_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      gnt_q <= gnt_d;
      pri_q <= pri_d;
      we_q <= we_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      cnt_q <= cnt_d;
    end
  assign act = (st_q == ISSUE) || (st_q == WAIT_DONE);
  assign mem_en = act;
  assign mem_we = act & we_q;
  assign mem_re = act & ~we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign req0_ack = (st_q == ACK) & ~gnt_q;
  assign req1_ack = (st_q == ACK) & gnt_q;
  assign req0_err = req0_ack & err_q;
  assign req1_err = req1_ack & err_q;
  assign req0_rdata = rd0_q;
  assign req1_rdata = rd1_q;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles the arbiter waits for mem_done before it aborts an access.
REQ-002 Parameter GAP_CYCLES, default 2: the number of cycles mem_re and mem_we are both held low between accesses.
REQ-003 There SHALL be one clock, clk (input, 1 bit); all logic is rising-edge.
REQ-004 Reset rst (input, 1 bit) SHALL be asynchronous and active-high.
REQ-005 Each requester port n (n = 0, 1) SHALL have these signals:
- reqn_valid (in, 1): request pending.
- reqn_we (in, 1): 1 = write, 0 = read.
- reqn_addr (in, 18): word address.
- reqn_wdata (in, 16): write data.
- reqn_ack (out, 1): completion pulse.
- reqn_err (out, 1): timeout flag, valid with reqn_ack.
- reqn_rdata (out, 16): read data, valid with reqn_ack.
REQ-006 The RAM-controller side SHALL have these signals:
- mem_en (out, 1): enable.
- mem_re (out, 1): read strobe.
- mem_we (out, 1): write strobe.
- mem_addr (out, 18): address.
- mem_wdata (out, 16): write data.
- mem_rdata (in, 16): read data.
- mem_done (in, 1): asynchronous completion pulse of at least 2 clk periods.

Function
REQ-007 The state machine SHALL have states IDLE, ISSUE, WAIT_DONE, ACK and GAP.
REQ-008 In IDLE with any reqn_valid high, the arbiter SHALL grant, latch the winner's we, addr and wdata, and go to ISSUE on the next cycle.
REQ-009 Arbitration SHALL be round-robin: when both requesters are valid in the same cycle, the one not granted last wins; after reset, requester 0 wins.
REQ-010 In ISSUE, the arbiter SHALL drive mem_en=1, mem_addr, mem_wdata, and exactly one of mem_we (write) or mem_re (read), then enter WAIT_DONE.
REQ-011 mem_en, mem_addr, mem_wdata and the active strobe SHALL stay stable from ISSUE until WAIT_DONE exits.
REQ-012 mem_done SHALL pass through a two-flop synchronizer; WAIT_DONE exits to ACK on the synchronized rising edge.
REQ-013 On that edge, for a read, reqn_rdata SHALL capture mem_rdata.
REQ-014 In ACK, the granted reqn_ack SHALL pulse high for exactly one cycle and all mem strobes, including mem_en, SHALL drop to 0.
REQ-015 If TIMEOUT_CYCLES cycles pass in WAIT_DONE without the edge, the arbiter SHALL enter ACK with reqn_err=1 and leave reqn_rdata unchanged.
REQ-016 GAP SHALL hold mem_re=mem_we=0 for GAP_CYCLES cycles and SHALL not exit while the synchronized done is still high; it then returns to IDLE.
REQ-017 A requester SHALL hold valid and its fields until its ack; requester fields are sampled only at grant, so changes after grant are ignored.
REQ-018 A requester that drops valid before grant SHALL lose the request with no ack.
REQ-019 Minimum latency from valid to ack SHALL be 5 cycles (IDLE, ISSUE, 2 synchronizer cycles, ACK) plus the controller's done delay.
REQ-020 A new request from the same requester SHALL be accepted only at the next IDLE, so back-to-back throughput is one access per (latency + GAP_CYCLES).
REQ-021 reqn_ack and reqn_err SHALL never be high for both requesters in the same cycle.
REQ-022 mem_re and mem_we SHALL never be high in the same cycle.
REQ-023 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES without wrap, and SHALL clear on every entry to WAIT_DONE.

Reset
REQ-024 While rst=1, the arbiter SHALL be in IDLE with all of the following at 0, including during an active access: mem_en, mem_re, mem_we, mem_addr, mem_wdata, all reqn_ack, reqn_err and reqn_rdata, the timeout counter, the synchronizer flops, and last-grant (0).
REQ-025 On reset release mid-access, the arbiter SHALL issue no ack for the aborted access; the requester must re-present it.

Structure
REQ-026 A shared package SHALL hold the state encoding, address width (18), data width (16), and the TIMEOUT_CYCLES/GAP_CYCLES defaults.
REQ-027 There SHALL be one sub-module, done_sync: a two-flop synchronizer with rising-edge detect, asynchronously reset by rst.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Req0 writes 0xA5A5 to 0x00010, done returned after 8 cycles: mem_we pulses once, mem_addr=0x00010, req0_ack one cycle, req0_err=0.
- Req1 reads 0x3FFFF with mem_rdata=0x1234: mem_re only, req1_rdata=0x1234 at ack.
- Req0 and req1 valid in the same cycle after reset, repeated 4 times: grants alternate 0,1,0,1, with no double ack.
- mem_done never asserted: ack with err=1 after 64 WAIT_DONE cycles, strobes low, then GAP of 2 cycles.
- rst asserted in WAIT_DONE: all outputs 0 immediately; after release, no ack until a new valid.
- mem_done held high for 12 cycles: GAP extends until done falls, with no second access issued.
